// File: rtl/counter_deglitch_pkg.sv
// Shared definitions for the counter deglitcher: FSM state encoding and
// default bus widths.
package counter_pkg;

    // ACQUIRE searches for a +1 run; LOCKED tracks and repairs the stream.
    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_TOT_W = 16;

endpackage

// File: rtl/counter_deglitch_if.sv
// Bus between the glitchy counter stage, the deglitcher and its consumers.
// There is no handshake: glitchy_counter is a free-running sample taken at
// every rising clock edge, and every output is a registered level valid at
// every edge. The master modport drives the raw counter and observes the
// results; the slave modport is the deglitcher. state is the FSM debug view.
interface counter_deglitch_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TOT_W = DEF_TOT_W
);
    logic [WIDTH-1:0] glitchy_counter;
    logic [WIDTH-1:0] clean_counter;
    logic             locked;
    logic             glitch_pulse;
    logic [TOT_W-1:0] glitch_total;
    state_t           state;

    modport master (
        output glitchy_counter,
        input  clean_counter, locked, glitch_pulse, glitch_total, state
    );

    modport slave (
        input  glitchy_counter,
        output clean_counter, locked, glitch_pulse, glitch_total, state
    );
endinterface

// File: rtl/counter_deglitch_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);
    // Count increments, holding once every bit is set.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + {{(W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/counter_deglitch.sv
// Locks onto a +1-per-clock counter stream, replaces isolated bad samples by
// the extrapolated value, tallies them, and drops lock after a run of
// consecutive bad samples. All outputs are registered.
module counter_deglitch
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_RUN = 4,
    parameter int MAX_MISS = 3,
    parameter int TOT_W    = DEF_TOT_W
) (
    input  logic              clk_in,
    input  logic              rst,
    counter_deglitch_if.slave bus
);
    localparam int MW = $clog2(LOCK_RUN + 1);
    localparam int XW = $clog2(MAX_MISS + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] clean_q;
    logic [MW-1:0]    match_cnt;
    logic [XW-1:0]    miss_cnt;
    logic             locked_q;
    logic             pulse_q;

    logic             acq_step;
    logic             lock_step;
    logic [MW-1:0]    match_next;
    logic [XW-1:0]    miss_next;
    logic             glitch_inc;

    // Successor tests against the previous sample (ACQUIRE) or the clean
    // value (LOCKED); addition wraps at WIDTH bits so FF->00 is a valid step.
    always_comb begin
        acq_step   = (in_q == cand + ONE);
        lock_step  = (in_q == clean_q + ONE);
        match_next = acq_step ? match_cnt + MW'(1) : '0;
        miss_next  = miss_cnt + XW'(1);
        glitch_inc = (state == LOCKED) && !lock_step;
    end

    // Input register, lock FSM, run counters and clean output register.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state     <= ACQUIRE;
            in_q      <= '0;
            cand      <= '0;
            clean_q   <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked_q  <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            in_q <= bus.glitchy_counter;
            cand <= in_q;
            case (state)
                ACQUIRE: begin
                    locked_q <= 1'b0;
                    pulse_q  <= 1'b0;
                    if (match_next == MW'(LOCK_RUN)) begin
                        state     <= LOCKED;
                        clean_q   <= in_q;
                        locked_q  <= 1'b1;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                    end else begin
                        match_cnt <= match_next;
                    end
                end
                LOCKED: begin
                    if (lock_step) begin
                        clean_q  <= in_q;
                        miss_cnt <= '0;
                        pulse_q  <= 1'b0;
                    end else begin
                        pulse_q <= 1'b1;
                        if (miss_next == XW'(MAX_MISS)) begin
                            // Exit cycle: clean value holds, no extrapolation.
                            state     <= ACQUIRE;
                            locked_q  <= 1'b0;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            clean_q  <= clean_q + ONE;
                            miss_cnt <= miss_next;
                        end
                    end
                end
                default: state <= ACQUIRE;
            endcase
        end
    end

    sat_counter #(.W(TOT_W)) u_glitch_total (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (glitch_inc),
        .value  (bus.glitch_total)
    );

    assign bus.clean_counter = clean_q;
    assign bus.locked        = locked_q;
    assign bus.glitch_pulse  = pulse_q;
    assign bus.state         = state;
endmodule
